// File: rtl/mux4x1_rr_merge_if.sv
// Valid/ready bundle for the 4-to-1 round-robin merge: four input channels, one tagged output.
interface mux4x1_rr_merge_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned N_CH = 4;

    logic [N_CH-1:0]       in_valid;
    logic [N_CH-1:0]       in_ready;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic [1:0]            out_sel;
    logic                  out_last;

    // Traffic source / sink side
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_sel, out_last
    );

    // Merge block side
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_sel, out_last
    );
endinterface

// File: rtl/mux4x1_rr_merge.sv
// Packet-aware 4:1 round-robin merge with a single registered output stage.
// A winning channel holds the output until its last beat; the pointer moves on packet end.
module mux4x1_rr_merge #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    mux4x1_rr_merge_if.slave bus
);
    localparam int unsigned N_CH = 4;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [1:0]      ptr;
    logic [1:0]      ptr_nxt;
    logic [1:0]      cur;
    logic [1:0]      cur_nxt;
    logic [1:0]      grant;
    logic            grant_vld;
    logic            load;
    logic            accept;
    logic [N_CH-1:0] ready_c;

    logic             vld_q;
    logic [WIDTH-1:0] data_q;
    logic [1:0]       sel_q;
    logic             last_q;

    // Output stage can take a new beat when empty or draining this cycle
    assign load   = !vld_q || bus.out_ready;
    assign accept = load && grant_vld;

    // Grant: locked channel only, otherwise first valid channel starting at ptr
    always_comb begin
        logic [1:0] idx;
        grant     = 2'd0;
        grant_vld = 1'b0;
        idx       = 2'd0;
        if (state == LOCK) begin
            grant     = cur;
            grant_vld = bus.in_valid[cur];
        end else begin
            for (int k = N_CH - 1; k >= 0; k--) begin
                idx = ptr + 2'(k);
                if (bus.in_valid[idx]) begin
                    grant     = idx;
                    grant_vld = 1'b1;
                end
            end
        end
    end

    // Next state, pointer/lock update and one-hot accept
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cur_nxt   = cur;
        ready_c   = '0;
        if (!rst) begin
            ready_c[grant] = accept;
        end
        if (accept) begin
            if (bus.in_last[grant]) begin
                state_nxt = IDLE;
                ptr_nxt   = grant + 2'd1;
            end else begin
                state_nxt = LOCK;
                cur_nxt   = grant;
            end
        end
    end

    // Arbitration state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 2'd0;
            cur   <= 2'd0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            cur   <= cur_nxt;
        end
    end

    // Output register: load on accept, drop valid when drained with nothing new
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            sel_q  <= 2'd0;
            last_q <= 1'b0;
        end else if (accept) begin
            vld_q  <= 1'b1;
            data_q <= bus.in_data[grant*WIDTH +: WIDTH];
            sel_q  <= grant;
            last_q <= bus.in_last[grant];
        end else if (load) begin
            vld_q  <= 1'b0;
        end
    end

    assign bus.in_ready  = ready_c;
    assign bus.out_valid = vld_q;
    assign bus.out_data  = data_q;
    assign bus.out_sel   = sel_q;
    assign bus.out_last  = last_q;
endmodule

// File: tb/tb_mux4x1_rr_merge.sv
// Directed bench for the 4:1 round-robin merge; inputs driven and outputs sampled on negedge.
module tb_mux4x1_rr_merge;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    mux4x1_rr_merge_if #(.WIDTH(8)) bus ();

    mux4x1_rr_merge #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_ch(input int i, input logic v, input logic [7:0] d, input logic l);
        bus.in_valid[i]       = v;
        bus.in_data[i*8 +: 8] = d;
        bus.in_last[i]        = l;
    endtask

    task automatic clear_inputs();
        bus.in_valid = '0;
        bus.in_data  = '0;
        bus.in_last  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        bus.out_ready = 1'b1;
        bus.in_valid  = 4'hF;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h expected 00", bus.out_data); end
        n_cmp++; if (bus.out_sel !== 2'd0) begin n_err++; $display("FAIL reset_out_sel: got %0d expected 0", bus.out_sel); end
        n_cmp++; if (bus.out_last !== 1'b0) begin n_err++; $display("FAIL reset_out_last: got %b expected 0", bus.out_last); end
        n_cmp++; if (bus.in_ready !== 4'b0000) begin n_err++; $display("FAIL reset_in_ready: got %b expected 0000", bus.in_ready); end
        bus.in_valid = '0;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (bus.in_ready !== 4'b0000) begin n_err++; $display("FAIL idle_in_ready: got %b expected 0000", bus.in_ready); end
    endtask

    task automatic test_single_beat();
        set_ch(1, 1'b1, 8'hA5, 1'b1);
        #1;
        n_cmp++; if (bus.in_ready !== 4'b0010) begin n_err++; $display("FAIL single_ready: got %b expected 0010", bus.in_ready); end
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b expected 1", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h expected a5", bus.out_data); end
        n_cmp++; if (bus.out_sel !== 2'd1) begin n_err++; $display("FAIL single_sel: got %0d expected 1", bus.out_sel); end
        n_cmp++; if (bus.out_last !== 1'b1) begin n_err++; $display("FAIL single_last: got %b expected 1", bus.out_last); end
        // ptr is now 2: with ch1..ch3 valid, ch2 must win
        set_ch(1, 1'b1, 8'hB1, 1'b1);
        set_ch(2, 1'b1, 8'hB2, 1'b1);
        set_ch(3, 1'b1, 8'hB3, 1'b1);
        #1;
        n_cmp++; if (bus.in_ready !== 4'b0100) begin n_err++; $display("FAIL ptr_after_single: got %b expected 0100", bus.in_ready); end
        @(negedge clk);
        n_cmp++; if (bus.out_data !== 8'hB2 || bus.out_sel !== 2'd2) begin n_err++; $display("FAIL ptr_beat: got %h/%0d expected b2/2", bus.out_data, bus.out_sel); end
        clear_inputs();
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid: got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_sel;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_ch(i, 1'b1, 8'(8'h10 + i), 1'b1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp_sel = 2'(k % 4);
            n_cmp++;
            if (bus.out_valid !== 1'b1 || bus.out_sel !== exp_sel || bus.out_data !== 8'(8'h10 + exp_sel) || bus.out_last !== 1'b1) begin
                n_err++;
                $display("FAIL rr_beat%0d: got v=%b sel=%0d data=%h expected v=1 sel=%0d data=%h", k, bus.out_valid, bus.out_sel, bus.out_data, exp_sel, 8'(8'h10 + exp_sel));
            end
        end
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_lock();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_ch(2, 1'b1, 8'h20, 1'b0);
        @(negedge clk);
        n_cmp++; if (bus.out_data !== 8'h20 || bus.out_sel !== 2'd2 || bus.out_last !== 1'b0) begin n_err++; $display("FAIL lock_beat0: got %h/%0d/%b expected 20/2/0", bus.out_data, bus.out_sel, bus.out_last); end
        set_ch(2, 1'b1, 8'h21, 1'b0);
        set_ch(0, 1'b1, 8'h05, 1'b1);
        #1;
        n_cmp++; if (bus.in_ready !== 4'b0100) begin n_err++; $display("FAIL lock_ready1: got %b expected 0100", bus.in_ready); end
        @(negedge clk);
        n_cmp++; if (bus.out_data !== 8'h21 || bus.out_sel !== 2'd2) begin n_err++; $display("FAIL lock_beat1: got %h/%0d expected 21/2", bus.out_data, bus.out_sel); end
        // Locked channel goes idle: nobody else may be granted
        set_ch(2, 1'b0, 8'h21, 1'b0);
        #1;
        n_cmp++; if (bus.in_ready !== 4'b0000) begin n_err++; $display("FAIL lock_gap_ready: got %b expected 0000", bus.in_ready); end
        @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL lock_gap_valid: got %b expected 0", bus.out_valid); end
        set_ch(2, 1'b1, 8'h22, 1'b1);
        #1;
        n_cmp++; if (bus.in_ready !== 4'b0100) begin n_err++; $display("FAIL lock_ready2: got %b expected 0100", bus.in_ready); end
        @(negedge clk);
        n_cmp++; if (bus.out_data !== 8'h22 || bus.out_sel !== 2'd2 || bus.out_last !== 1'b1) begin n_err++; $display("FAIL lock_beat2: got %h/%0d/%b expected 22/2/1", bus.out_data, bus.out_sel, bus.out_last); end
        set_ch(2, 1'b0, 8'h00, 1'b0);
        #1;
        n_cmp++; if (bus.in_ready !== 4'b0001) begin n_err++; $display("FAIL unlock_ready: got %b expected 0001", bus.in_ready); end
        @(negedge clk);
        n_cmp++; if (bus.out_data !== 8'h05 || bus.out_sel !== 2'd0 || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL unlock_beat: got %h/%0d/%b expected 05/0/1", bus.out_data, bus.out_sel, bus.out_valid); end
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b1;
        set_ch(1, 1'b1, 8'h33, 1'b1);
        @(negedge clk);
        n_cmp++; if (bus.out_data !== 8'h33 || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_first: got %h/%b expected 33/1", bus.out_data, bus.out_valid); end
        set_ch(1, 1'b0, 8'h00, 1'b0);
        set_ch(3, 1'b1, 8'h44, 1'b1);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_cmp++;
            if (bus.in_ready !== 4'b0000 || bus.out_data !== 8'h33 || bus.out_valid !== 1'b1 || bus.out_sel !== 2'd1) begin
                n_err++;
                $display("FAIL bp_hold%0d: got ready=%b data=%h v=%b sel=%0d expected 0000/33/1/1", k, bus.in_ready, bus.out_data, bus.out_valid, bus.out_sel);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        n_cmp++; if (bus.in_ready !== 4'b1000) begin n_err++; $display("FAIL bp_release_ready: got %b expected 1000", bus.in_ready); end
        @(negedge clk);
        n_cmp++; if (bus.out_data !== 8'h44 || bus.out_sel !== 2'd3 || bus.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_next: got %h/%0d/%b expected 44/3/1", bus.out_data, bus.out_sel, bus.out_valid); end
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_packet();
        set_ch(3, 1'b1, 8'h30, 1'b0);
        @(negedge clk);
        n_cmp++; if (bus.out_data !== 8'h30 || bus.out_sel !== 2'd3 || bus.out_last !== 1'b0) begin n_err++; $display("FAIL mid_beat0: got %h/%0d/%b expected 30/3/0", bus.out_data, bus.out_sel, bus.out_last); end
        set_ch(3, 1'b1, 8'h31, 1'b0);
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.in_ready !== 4'b0000) begin n_err++; $display("FAIL mid_reset: got v=%b data=%h ready=%b expected 0/00/0000", bus.out_valid, bus.out_data, bus.in_ready); end
        @(negedge clk);
        rst = 1'b0;
        set_ch(0, 1'b1, 8'h07, 1'b1);
        #1;
        n_cmp++; if (bus.in_ready !== 4'b0001) begin n_err++; $display("FAIL mid_regrant: got %b expected 0001", bus.in_ready); end
        @(negedge clk);
        n_cmp++; if (bus.out_data !== 8'h07 || bus.out_sel !== 2'd0 || bus.out_last !== 1'b1) begin n_err++; $display("FAIL mid_beat: got %h/%0d/%b expected 07/0/1", bus.out_data, bus.out_sel, bus.out_last); end
        clear_inputs();
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.out_ready = 1'b1;
        clear_inputs();
        @(negedge clk);
        test_reset();
        test_single_beat();
        test_round_robin();
        test_lock();
        test_backpressure();
        test_reset_mid_packet();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
